mem_fill_arbiter: RTL
=====================

Name: mem_fill_arbiter

Overview:
- Shares the single-ported, multi-cycle main memory between I-cache miss fills, D-cache miss fills and D-cache write-through stores (SW).
- Sequences each 16-byte block fill as 8 pipelined word reads and streams the returned words into the requesting cache.
- Sits between the two cache controllers and the memory model; the pipeline stalls on any cache while its request is pending.

Parameters:
- ADDR_W, 16, byte address width
- DATA_W, 16, memory word width
- WORDS, 8, words per cache block (16 bytes / 2)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- i_miss_req  in  1  I-cache miss, level, held until i_fill_done
- i_miss_addr  in  ADDR_W  I-cache miss byte address
- d_miss_req  in  1  D-cache miss, level, held until d_fill_done
- d_miss_addr  in  ADDR_W  D-cache miss byte address
- d_wr_req  in  1  write-through store, level, held until d_wr_ack
- d_wr_addr  in  ADDR_W  store address
- d_wr_data  in  DATA_W  store data
- mem_en  out  1  memory request strobe
- mem_wr  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_rvalid  in  1  read data valid (fixed latency 4 cycles after mem_en read)
- fill_data  out  DATA_W  returned word to cache
- fill_word  out  3  word index within block
- i_fill_we  out  1  write fill_data into I-cache
- d_fill_we  out  1  write fill_data into D-cache
- i_fill_done  out  1  one-cycle pulse, I-cache fill complete
- d_fill_done  out  1  one-cycle pulse, D-cache fill complete
- d_wr_ack  out  1  one-cycle pulse, store accepted
- busy  out  1  state != IDLE

Behaviour:
- Clocking: one clock, clk; reset is asynchronous, active-low (rst_n).
- Reset state: IDLE, counters 0, owner cleared.
  - All outputs are 0 in reset: mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word, all we, all done pulses, d_wr_ack and busy.
- States: IDLE, WRITE, ISSUE, DRAIN, DONE.
- Arbitration happens only in IDLE. Fixed priority: d_wr_req > d_miss_req > i_miss_req. A request arriving mid-operation waits.
- IDLE -> WRITE on d_wr_req.
  - WRITE lasts exactly 1 cycle: mem_en=1, mem_wr=1, mem_addr=d_wr_addr, mem_wdata=d_wr_data, d_wr_ack=1.
  - Then -> IDLE.
- IDLE -> ISSUE on a miss.
  - Latch owner (I or D) and base = miss_addr with bits [3:0] forced to 0.
- ISSUE lasts 8 cycles, issue counter k = 0..7: mem_en=1, mem_wr=0, mem_addr = base + 2k. The 16-bit add wraps.
  - After k=7 -> DRAIN; skipped if all 8 words have already returned.
- Receive path, active in ISSUE and DRAIN:
  - Each mem_rvalid: fill_data=mem_rdata and fill_word=receive counter r, combinationally from the input.
  - The owner's fill_we=1 on that cycle; r increments.
  - With latency 4, ISSUE and DRAIN overlap.
- r==7 with rvalid -> DONE.
  - DONE lasts 1 cycle: owner's fill_done=1, then -> IDLE.
  - The requester must drop its req by the cycle after done.
- Latency: write = 1 cycle from grant. Fill = 8 issue + 4 latency = 12 cycles from the first mem_en to the last fill_we, plus 1 cycle DONE.
- mem_rvalid in IDLE, WRITE or DONE is ignored: no we and no counter change.
- Simultaneous d_wr_req and d_miss_req in IDLE: write first; the miss is granted the next IDLE cycle.
- Reset asserted mid-fill: immediate return to IDLE with all outputs 0. No done pulse. Late rvalids are ignored.
- Outputs not driven by the current state are 0. The mem_addr and mem_wdata registers hold 0 when mem_en=0.

Decomposition:
- Shared package wisc_mem_pkg holds:
  - the state enum type
  - WORDS = 8
  - BLOCK_OFF_W = 4
  - MEM_LAT = 4
  - owner enum (OWN_I, OWN_D)
- Natural sub-module: block_word_counter, a 3-bit counter with clear, increment and terminal-count output. It is instantiated twice, once for issue and once for receive.

Test Plan:
- I miss only, i_miss_addr=0x1236 -> mem_en reads at 0x1230, 0x1232 … 0x123E on 8 consecutive cycles. Returned words 0xA000..0xA007 give i_fill_we with fill_word 0..7, then a single i_fill_done pulse. d_fill_we stays 0 throughout.
- i_miss_req and d_miss_req asserted in the same cycle, addrs 0x0040 and 0x8000 -> D fill of 0x8000..0x800E completes with d_fill_done. Then the I fill of 0x0040..0x004E runs; busy stays 0 for exactly 1 cycle between the two fills.
- d_wr_req (0x2000, 0xBEEF) plus d_miss_req (0x3000) together -> cycle 1: mem_en=1, mem_wr=1, addr 0x2000, data 0xBEEF, d_wr_ack=1. Fill of 0x3000 is granted after the return to IDLE.
- d_wr_req asserted on the 3rd cycle of an I fill -> no mem write until after i_fill_done. The write then completes in 1 cycle with ack.
- Wrap case, d_miss_addr=0xFFF8 -> reads at 0xFFF0..0xFFFE, with no carry into other addresses.
- rst_n low during the 5th issue cycle -> all outputs 0 immediately. Subsequent stray mem_rvalid pulses produce no we and no done. A new i_miss_req after reset is serviced normally.

Source files
------------

// File: rtl/wisc_mem_pkg.sv
// Shared types and constants for the memory fill arbiter: FSM states, fill owner
// and block geometry (16-byte blocks of 2-byte words).
package wisc_mem_pkg;
  localparam int WORDS       = 8;
  localparam int WORD_IDX_W  = $clog2(WORDS);
  localparam int BLOCK_OFF_W = 4;
  localparam int MEM_LAT     = 4;

  typedef enum logic [2:0] {IDLE, WRITE, ISSUE, DRAIN, DONE} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;
endpackage

// File: rtl/block_word_counter.sv
// Word index counter within a cache block; clear wins over increment and tc flags
// the last word of the block.
module block_word_counter
  import wisc_mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  inc,
  output logic [WORD_IDX_W-1:0] count,
  output logic                  tc
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + WORD_IDX_W'(1);
    end
  end

  assign tc = (count == WORD_IDX_W'(WORDS - 1));
endmodule

// File: rtl/mem_fill_arbiter.sv
// Arbitrates the single memory port between D-cache stores, D-cache fills and
// I-cache fills; fills are issued as 8 pipelined reads and streamed back to the owner.
module mem_fill_arbiter
  import wisc_mem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_miss_req,
  input  logic [ADDR_W-1:0]     i_miss_addr,
  input  logic                  d_miss_req,
  input  logic [ADDR_W-1:0]     d_miss_addr,
  input  logic                  d_wr_req,
  input  logic [ADDR_W-1:0]     d_wr_addr,
  input  logic [DATA_W-1:0]     d_wr_data,
  output logic                  mem_en,
  output logic                  mem_wr,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_rvalid,
  output logic [DATA_W-1:0]     fill_data,
  output logic [WORD_IDX_W-1:0] fill_word,
  output logic                  i_fill_we,
  output logic                  d_fill_we,
  output logic                  i_fill_done,
  output logic                  d_fill_done,
  output logic                  d_wr_ack,
  output logic                  busy,
  output state_t                fsm_state
);
  // Handshake: each *_req is a level held by the cache until its one-cycle
  // completion pulse (i_fill_done / d_fill_done / d_wr_ack) and dropped by the
  // following cycle; requests are only sampled while the FSM sits in IDLE.
  state_t                state;
  owner_t                owner;
  logic [ADDR_W-1:0]     base;
  logic [ADDR_W-1:0]     i_base;
  logic [ADDR_W-1:0]     d_base;
  logic [ADDR_W-1:0]     next_addr;
  logic [WORD_IDX_W-1:0] issue_cnt;
  logic [WORD_IDX_W-1:0] rx_cnt;
  logic                  issue_tc;
  logic                  rx_tc;
  logic                  rx_active;
  logic                  rx_fire;
  logic                  fill_last;

  assign i_base    = {i_miss_addr[ADDR_W-1:BLOCK_OFF_W], {BLOCK_OFF_W{1'b0}}};
  assign d_base    = {d_miss_addr[ADDR_W-1:BLOCK_OFF_W], {BLOCK_OFF_W{1'b0}}};
  assign next_addr = base + {{(ADDR_W-WORD_IDX_W-1){1'b0}}, issue_cnt + WORD_IDX_W'(1), 1'b0};

  assign rx_active = (state == ISSUE) || (state == DRAIN);
  assign rx_fire   = rx_active && mem_rvalid;
  assign fill_last = rx_fire && rx_tc;

  // Returned words bypass the FSM so the cache sees them in the rvalid cycle.
  assign fill_data = rx_fire ? mem_rdata : '0;
  assign fill_word = rx_fire ? rx_cnt : '0;
  assign i_fill_we = rx_fire && (owner == OWN_I);
  assign d_fill_we = rx_fire && (owner == OWN_D);
  assign busy      = (state != IDLE);
  assign fsm_state = state;

  block_word_counter u_issue_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == IDLE),
    .inc   (state == ISSUE),
    .count (issue_cnt),
    .tc    (issue_tc)
  );

  block_word_counter u_rx_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == IDLE),
    .inc   (rx_fire),
    .count (rx_cnt),
    .tc    (rx_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= OWN_I;
      base        <= '0;
      mem_en      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      d_wr_ack    <= 1'b0;
      i_fill_done <= 1'b0;
      d_fill_done <= 1'b0;
    end else begin
      mem_en      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      d_wr_ack    <= 1'b0;
      i_fill_done <= 1'b0;
      d_fill_done <= 1'b0;
      case (state)
        IDLE: begin
          if (d_wr_req) begin
            state     <= WRITE;
            mem_en    <= 1'b1;
            mem_wr    <= 1'b1;
            mem_addr  <= d_wr_addr;
            mem_wdata <= d_wr_data;
            d_wr_ack  <= 1'b1;
          end else if (d_miss_req) begin
            state    <= ISSUE;
            owner    <= OWN_D;
            base     <= d_base;
            mem_en   <= 1'b1;
            mem_addr <= d_base;
          end else if (i_miss_req) begin
            state    <= ISSUE;
            owner    <= OWN_I;
            base     <= i_base;
            mem_en   <= 1'b1;
            mem_addr <= i_base;
          end
        end
        WRITE: state <= IDLE;
        ISSUE: begin
          if (fill_last) begin
            state       <= DONE;
            i_fill_done <= (owner == OWN_I);
            d_fill_done <= (owner == OWN_D);
          end else if (issue_tc) begin
            state <= DRAIN;
          end else begin
            mem_en   <= 1'b1;
            mem_addr <= next_addr;
          end
        end
        DRAIN: begin
          if (fill_last) begin
            state       <= DONE;
            i_fill_done <= (owner == OWN_I);
            d_fill_done <= (owner == OWN_D);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
